// File: rtl/flappy_pkg.sv
// Shared constants and encodings for the flappy-bird core.
package flappy_pkg;

  localparam int unsigned PIX_CLK_HZ          = 25_000_000;
  // 10 ms stable window and 1 s hold at the pixel clock
  localparam int unsigned DEBOUNCE_CYCLES_DEF = PIX_CLK_HZ / 100;
  localparam int unsigned LONG_CYCLES_DEF     = PIX_CLK_HZ;

  typedef enum logic [1:0] {
    BTN_IDLE         = 2'd0,
    BTN_PRESS_WAIT   = 2'd1,
    BTN_HELD         = 2'd2,
    BTN_RELEASE_WAIT = 2'd3
  } btn_state_e;

endpackage

// File: rtl/button_ctrl_if.sv
// Button pin, frame tick and conditioned button events.
interface button_ctrl_if;

  logic button;
  logic frame_tick;
  logic pressed;
  logic press;
  logic release_pulse;
  logic long_press;
  logic flap;

  modport master (
    output button,
    output frame_tick,
    input  pressed,
    input  press,
    input  release_pulse,
    input  long_press,
    input  flap
  );

  modport slave (
    input  button,
    input  frame_tick,
    output pressed,
    output press,
    output release_pulse,
    output long_press,
    output flap
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture; reset to the idle level of the input
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_ctrl.sv
// Debounces the game button and produces press/release/long-press
// events plus a frame-aligned flap pulse.
module button_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input logic          clk,
  input logic          rst,
  button_ctrl_if.slave bus
);

  localparam int unsigned      CNT_W     = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_FIRE = CNT_W'(LONG_CYCLES - 2);

  logic pin_level;
  logic level;

  btn_state_e       state, state_next;
  logic [CNT_W-1:0] db_cnt, db_cnt_next;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
  logic             hold_run;
  logic             pressed_q, pressed_next;
  logic             press_q, press_next;
  logic             rel_q, rel_next;
  logic             long_q, long_next;
  logic             flap_q, flap_next;
  logic             flap_req, flap_req_next;

  // Normalise polarity so a pressed button always reads 1
  assign pin_level = bus.button ^ ACTIVE_LOW;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pin_level),
    .q   (level)
  );

  // Next-state, counter and event decode
  always_comb begin
    state_next    = state;
    db_cnt_next   = db_cnt;
    hold_cnt_next = hold_cnt;
    hold_run      = 1'b0;
    press_next    = 1'b0;
    rel_next      = 1'b0;
    long_next     = 1'b0;
    flap_next     = 1'b0;
    flap_req_next = flap_req;

    case (state)
      BTN_IDLE: begin
        if (level) begin
          state_next  = BTN_PRESS_WAIT;
          db_cnt_next = '0;
        end
      end
      BTN_PRESS_WAIT: begin
        if (!level) begin
          state_next = BTN_IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_next    = BTN_HELD;
          hold_cnt_next = '0;
          press_next    = 1'b1;
        end else begin
          db_cnt_next = db_cnt + CNT_W'(1);
        end
      end
      BTN_HELD: begin
        hold_run = 1'b1;
        if (!level) begin
          state_next  = BTN_RELEASE_WAIT;
          db_cnt_next = '0;
        end
      end
      BTN_RELEASE_WAIT: begin
        // Bounce back to HELD keeps the hold count running
        hold_run = 1'b1;
        if (level) begin
          state_next = BTN_HELD;
        end else if (db_cnt == DB_LAST) begin
          state_next = BTN_IDLE;
          rel_next   = 1'b1;
        end else begin
          db_cnt_next = db_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = BTN_IDLE;
      end
    endcase

    // Saturating hold count; long_press fires once as it reaches LONG-1
    if (hold_run && (hold_cnt != HOLD_MAX)) begin
      hold_cnt_next = hold_cnt + CNT_W'(1);
      long_next     = (hold_cnt == HOLD_FIRE);
    end

    pressed_next = (state_next == BTN_HELD) || (state_next == BTN_RELEASE_WAIT);

    // A press coinciding with the tick is issued directly, never latched
    if (bus.frame_tick) begin
      flap_next     = flap_req | press_q;
      flap_req_next = 1'b0;
    end else begin
      flap_req_next = flap_req | press_q;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BTN_IDLE;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      long_q    <= 1'b0;
      flap_q    <= 1'b0;
      flap_req  <= 1'b0;
    end else begin
      state     <= state_next;
      db_cnt    <= db_cnt_next;
      hold_cnt  <= hold_cnt_next;
      pressed_q <= pressed_next;
      press_q   <= press_next;
      rel_q     <= rel_next;
      long_q    <= long_next;
      flap_q    <= flap_next;
      flap_req  <= flap_req_next;
    end
  end

  assign bus.pressed       = pressed_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.long_press    = long_q;
  assign bus.flap          = flap_q;

endmodule
